// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data-access paths.
// One access at a time: latch request, hold strobes until memory is ready, return data.
//
// state  | meaning
// IDLE   | port free, arbitrate pending requests
// ACC_I  | fetch strobe on memory, waiting for MEM_BUSYWAIT low
// ACC_D  | data strobe on memory, waiting for MEM_BUSYWAIT low
// DONE_I | fetch complete, I_BUSYWAIT released for one cycle
// DONE_D | data access complete, D_BUSYWAIT released for one cycle
module mem_port_arbiter #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [3:0] IFETCH_RD_CODE = 4'b0010,
  parameter bit         DATA_PRIORITY  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic [3:0]            D_READ,
  input  logic [2:0]            D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic [3:0]            MEM_READ,
  output logic [2:0]            MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic                  GRANT_D
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_I  = 3'd1,
    ACC_D  = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   i_req, d_req, pick_d;
  logic   last_grant_d;

  assign i_req  = I_READ;
  assign d_req  = (D_READ != 4'd0) || (D_WRITE != 3'd0);
  // On a tie the data path wins unless it also won the previous grant.
  assign pick_d = d_req && (!i_req || DATA_PRIORITY || !last_grant_d);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d)     state_nxt = ACC_D;
        else if (i_req) state_nxt = ACC_I;
      end
      ACC_I:   if (!MEM_BUSYWAIT) state_nxt = DONE_I;
      ACC_D:   if (!MEM_BUSYWAIT) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_READ      <= '0;
      MEM_WRITE     <= '0;
      MEM_ADDR      <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
      last_grant_d  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == ACC_D) begin
            MEM_ADDR      <= D_ADDR;
            MEM_WRITEDATA <= D_WRITEDATA;
            MEM_WRITE     <= D_WRITE;
            // A combined read+write request is treated as a write.
            MEM_READ      <= (D_WRITE != 3'd0) ? 4'd0 : D_READ;
            last_grant_d  <= 1'b1;
          end else if (state_nxt == ACC_I) begin
            MEM_ADDR      <= I_ADDR;
            MEM_READ      <= IFETCH_RD_CODE;
            MEM_WRITE     <= '0;
            last_grant_d  <= 1'b0;
          end
        end
        ACC_I: begin
          if (!MEM_BUSYWAIT) begin
            I_READDATA <= MEM_READDATA;
            MEM_READ   <= '0;
            MEM_WRITE  <= '0;
          end
        end
        ACC_D: begin
          if (!MEM_BUSYWAIT) begin
            if (MEM_READ != 4'd0) D_READDATA <= MEM_READDATA;
            MEM_READ  <= '0;
            MEM_WRITE <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    I_BUSYWAIT = i_req && (state != DONE_I);
    D_BUSYWAIT = d_req && (state != DONE_D);
    GRANT_D    = (state == ACC_D) || (state == DONE_D);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, and a data-priority instance.
module tb_mem_port_arbiter;
  localparam logic [3:0] IFC = 4'b0010;
  localparam logic [3:0] LW  = 4'b0010;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        I_READ = 1'b0;
  logic [31:0] I_ADDR = '0;
  logic [3:0]  D_READ = '0;
  logic [2:0]  D_WRITE = '0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WRITEDATA = '0;
  logic [31:0] I_READDATA, D_READDATA, MEM_ADDR, MEM_WRITEDATA, MEM_READDATA;
  logic        I_BUSYWAIT, D_BUSYWAIT, MEM_BUSYWAIT, GRANT_D;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;

  logic [31:0] I_READDATA_p, D_READDATA_p, MEM_ADDR_p, MEM_WRITEDATA_p;
  logic        I_BUSYWAIT_p, D_BUSYWAIT_p, GRANT_D_p;
  logic [3:0]  MEM_READ_p;
  logic [2:0]  MEM_WRITE_p;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IFETCH_RD_CODE(IFC), .DATA_PRIORITY(1'b0)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .GRANT_D(GRANT_D));

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IFETCH_RD_CODE(IFC), .DATA_PRIORITY(1'b1)) dut_p (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA_p), .I_BUSYWAIT(I_BUSYWAIT_p),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA_p), .D_BUSYWAIT(D_BUSYWAIT_p),
    .MEM_READ(MEM_READ_p), .MEM_WRITE(MEM_WRITE_p), .MEM_ADDR(MEM_ADDR_p), .MEM_WRITEDATA(MEM_WRITEDATA_p),
    .MEM_READDATA(32'h1234_5678), .MEM_BUSYWAIT(1'b0), .GRANT_D(GRANT_D_p));

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: busy for mem_lat cycles after the strobe appears, then ready.
  logic [31:0] mem [0:255];
  int  mem_lat = 0;
  int  mem_cnt = 0;
  wire strobe = (MEM_READ != 4'd0) || (MEM_WRITE != 3'd0);
  assign MEM_BUSYWAIT = strobe && (mem_cnt != 0);
  assign MEM_READDATA = mem[MEM_ADDR[9:2]];

  always @(posedge CLK) begin
    if (!strobe) mem_cnt <= mem_lat;
    else if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
    if (RESET) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 | k;
      mem[16] <= 32'h0050_0093;
    end else if (MEM_WRITE != 3'd0 && !MEM_BUSYWAIT) begin
      mem[MEM_ADDR[9:2]] <= MEM_WRITEDATA;
    end
  end

  // Reference model: one outstanding transaction, owner/phase bookkeeping.
  int          m_phase = 0;
  int          m_owner = -1;
  int          m_left = 0;
  bit          m_last_d = 1'b0;
  logic [3:0]  m_rd = '0;
  logic [2:0]  m_wr = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ir = '0, m_dr = '0;
  wire m_dreq = (D_READ != 4'd0) || (D_WRITE != 3'd0);
  wire m_dwin = m_dreq && (!I_READ || !m_last_d);

  always @(posedge CLK) begin
    if (RESET) begin
      m_phase <= 0; m_owner <= -1; m_last_d <= 1'b0; m_rd <= '0; m_wr <= '0;
      m_addr <= '0; m_wdata <= '0; m_ir <= '0; m_dr <= '0;
    end else if (m_phase == 0) begin
      if (m_dreq || I_READ) begin
        m_phase  <= 1;
        m_left   <= mem_lat;
        m_owner  <= m_dwin ? 1 : 0;
        m_last_d <= m_dwin;
        if (m_dwin) begin
          m_addr <= D_ADDR; m_wdata <= D_WRITEDATA; m_wr <= D_WRITE;
          m_rd   <= (D_WRITE != 3'd0) ? 4'd0 : D_READ;
        end else begin
          m_addr <= I_ADDR; m_rd <= IFC; m_wr <= '0;
        end
      end
    end else if (m_phase == 1) begin
      if (m_left == 0) begin
        if (m_owner == 1) begin
          if (m_rd != 4'd0) m_dr <= mem[m_addr[9:2]];
        end else begin
          m_ir <= mem[m_addr[9:2]];
        end
        m_rd <= '0; m_wr <= '0; m_phase <= 2;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_phase <= 0; m_owner <= -1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("mem_read", MEM_READ, m_rd);
      chk("mem_write", MEM_WRITE, m_wr);
      chk("mem_addr", MEM_ADDR, m_addr);
      chk("mem_wdata", MEM_WRITEDATA, m_wdata);
      chk("i_rdata", I_READDATA, m_ir);
      chk("d_rdata", D_READDATA, m_dr);
      chk("grant_d", GRANT_D, (m_owner == 1));
      chk("i_busy", I_BUSYWAIT, I_READ && !(m_phase == 2 && m_owner == 0));
      chk("d_busy", D_BUSYWAIT, m_dreq && !(m_phase == 2 && m_owner == 1));
    end
  end

  // Access snapshots, grant order and busywait-release counts.
  logic        prev_strobe = 1'b0;
  int          grant_q[$];
  logic [3:0]  snap_rd;
  logic [2:0]  snap_wr;
  logic [31:0] snap_addr;
  int          ib_low = 0;

  always @(negedge CLK) begin
    if (strobe && !prev_strobe) begin
      grant_q.push_back(int'(GRANT_D));
      snap_rd = MEM_READ; snap_wr = MEM_WRITE; snap_addr = MEM_ADDR;
    end
    prev_strobe = strobe;
    if (I_READ && !I_BUSYWAIT) ib_low++;
  end

  task automatic i_txn(input logic [31:0] addr, input bit last, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    I_READ = 1'b1; I_ADDR = addr;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLK);
      cyc++;
      if (!I_BUSYWAIT) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL i_timeout: I_BUSYWAIT still %b after %0d cycles, required 0", I_BUSYWAIT, cyc);
    end
    @(posedge CLK); #1;
    if (last) I_READ = 1'b0;
  endtask

  task automatic d_txn(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit last, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    D_READ = rd; D_WRITE = wr; D_ADDR = addr; D_WRITEDATA = wdata;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLK);
      cyc++;
      if (!D_BUSYWAIT) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL d_timeout: D_BUSYWAIT still %b after %0d cycles, required 0", D_BUSYWAIT, cyc);
    end
    @(posedge CLK); #1;
    if (last) begin D_READ = '0; D_WRITE = '0; end
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
  endtask

  int cyc_a, cyc_b, p_grants;
  int exp_order[6] = '{1, 0, 1, 0, 1, 0};

  initial begin
    repeat (2) @(posedge CLK);
    chk_en = 1'b1;
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_i_rdata", I_READDATA, 32'h0);
    chk("rst_d_rdata", D_READDATA, 32'h0);
    chk("rst_strobes", {MEM_READ, 1'b0, MEM_WRITE}, 8'h00);

    // Fetch with a 2-cycle busy memory.
    mem_lat = 2; ib_low = 0;
    @(posedge CLK); #1;
    i_txn(32'h40, 1'b1, cyc_a);
    repeat (2) @(negedge CLK);
    chk("fetch_rd_code", snap_rd, IFC);
    chk("fetch_addr", snap_addr, 32'h40);
    chk("fetch_latency", cyc_a, 5);
    chk("fetch_release", ib_low, 1);
    chk("fetch_word", I_READDATA, 32'h0050_0093);

    // Store, then load back the stored word.
    mem_lat = 1;
    @(posedge CLK); #1;
    d_txn(4'd0, 3'b011, 32'h100, 32'hDEAD_BEEF, 1'b1, cyc_a);
    @(negedge CLK);
    chk("store_wr_code", snap_wr, 3'b011);
    chk("store_rd_code", snap_rd, 4'd0);
    chk("store_latency", cyc_a, 4);
    chk("store_d_rdata", D_READDATA, 32'h0);
    chk("store_i_rdata", I_READDATA, 32'h0050_0093);
    chk("store_mem", mem[64], 32'hDEAD_BEEF);
    mem_lat = 0;
    @(posedge CLK); #1;
    d_txn(LW, 3'd0, 32'h100, 32'h0, 1'b1, cyc_a);
    @(negedge CLK);
    chk("load_latency", cyc_a, 3);
    chk("load_word", D_READDATA, 32'hDEAD_BEEF);

    // Read and write codes together: write wins.
    @(posedge CLK); #1;
    d_txn(LW, 3'b010, 32'h20, 32'h1357_2468, 1'b1, cyc_a);
    @(negedge CLK);
    chk("rw_rd_code", snap_rd, 4'd0);
    chk("rw_wr_code", snap_wr, 3'b010);
    chk("rw_d_rdata", D_READDATA, 32'hDEAD_BEEF);
    chk("rw_mem", mem[8], 32'h1357_2468);

    // Tie after reset, requests held back-to-back: D first, then alternate.
    pulse_reset();
    grant_q.delete();
    @(posedge CLK); #1;
    fork
      begin
        d_txn(LW, 3'd0, 32'h80, 32'h0, 1'b0, cyc_a);
        d_txn(LW, 3'd0, 32'h84, 32'h0, 1'b0, cyc_a);
        d_txn(LW, 3'd0, 32'h88, 32'h0, 1'b1, cyc_a);
      end
      begin
        i_txn(32'h40, 1'b0, cyc_b);
        i_txn(32'h44, 1'b0, cyc_b);
        i_txn(32'h48, 1'b1, cyc_b);
      end
    join
    repeat (2) @(negedge CLK);
    chk("tie_count", grant_q.size(), 6);
    for (int k = 0; k < 6 && k < grant_q.size(); k++) chk("tie_order", grant_q[k], exp_order[k]);
    chk("tie_d_last", D_READDATA, 32'hA000_0022);
    chk("tie_i_last", I_READDATA, 32'hA000_0012);

    // Both requests held continuously: data-priority instance never serves I.
    repeat (4) @(posedge CLK);
    #1 I_READ = 1'b1; I_ADDR = 32'h44; D_READ = LW; D_ADDR = 32'h88;
    p_grants = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      chk("dp1_i_busy", I_BUSYWAIT_p, 1'b1);
      if (MEM_READ_p != 4'd0) begin
        p_grants++;
        chk("dp1_grant", GRANT_D_p, 1'b1);
      end
    end
    chk("dp1_accesses", p_grants, 5);
    @(posedge CLK); #1 I_READ = 1'b0; D_READ = '0;
    repeat (4) @(posedge CLK);

    // Reset during a busy data access.
    mem_lat = 5;
    #1 D_READ = LW; D_ADDR = 32'h100;
    for (int k = 0; k < 20 && MEM_READ == 4'd0; k++) @(negedge CLK);
    chk("mid_in_acc", GRANT_D && MEM_BUSYWAIT, 1'b1);
    @(posedge CLK); #1 RESET = 1'b1; D_READ = '0;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("mid_strobes", {MEM_READ, 1'b0, MEM_WRITE}, 8'h00);
    chk("mid_addr", MEM_ADDR, 32'h0);
    chk("mid_wdata", MEM_WRITEDATA, 32'h0);
    chk("mid_rdata", I_READDATA | D_READDATA, 32'h0);
    chk("mid_grant", GRANT_D, 1'b0);
    mem_lat = 2;
    @(posedge CLK); #1;
    i_txn(32'h40, 1'b1, cyc_a);
    @(negedge CLK);
    chk("post_rst_latency", cyc_a, 5);
    chk("post_rst_word", I_READDATA, 32'h0050_0093);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end
endmodule
